// File: rtl/juego_pkg.sv
`default_nettype none
// ============================================================================
//  Package : juego_pkg
//  Shared state encoding and score-width helper for the game reset control
//  block and its sub-modules.
//  Rev 1.0 - initial release
// ============================================================================
package juego_pkg;

  localparam int ST_W = 3;

  // Controller states
  localparam logic [ST_W-1:0] JUEGO    = 3'd0;
  localparam logic [ST_W-1:0] CELEBRA  = 3'd1;
  localparam logic [ST_W-1:0] REINICIO = 3'd2;
  localparam logic [ST_W-1:0] FIN      = 3'd3;
  localparam logic [ST_W-1:0] APAGADO  = 3'd4;

  // Bits needed to hold a score in the range 0..win_rounds
  function automatic int score_w(input int win_rounds);
    return $clog2(win_rounds + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/detector_flanco.sv
`default_nettype none
// ============================================================================
//  Module : detector_flanco
//  Rising-edge detector for one win-request channel. History resets to one
//  so a request already high when reset is released does not fire.
//  Rev 1.0 - initial release
// ============================================================================
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level, every cycle regardless of controller state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/game_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : game_reset_ctrl
//  Match controller: detects player win edges, keeps per-player scores,
//  runs a celebration hold, pulses the game-counter reset between rounds
//  and latches match-over / power-off conditions.
//  Rev 1.0 - initial release
// ============================================================================
module game_reset_ctrl
  import juego_pkg::*;
#(
  parameter  int N_JUG      = 2,
  parameter  int HOLD_CYC   = 4,
  parameter  int WIN_ROUNDS = 3,
  localparam int PW         = score_w(WIN_ROUNDS),
  localparam int HW         = $clog2(HOLD_CYC + 1)
) (
  input  logic                clk,
  input  logic                resetTotal,
  input  logic [N_JUG-1:0]    Ganador,
  input  logic                Apagar,
  output logic                resetContador,
  output logic [N_JUG-1:0]    ganadorRonda,
  output logic [N_JUG*PW-1:0] puntos,
  output logic                partidaFin
);

  localparam logic [PW-1:0]    C_SCORE_ONE = PW'(1);
  localparam logic [PW-1:0]    C_WIN       = PW'(WIN_ROUNDS);
  localparam logic [HW-1:0]    C_HOLD_INIT = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0]    C_HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]    C_HOLD_ZERO = '0;
  localparam logic [N_JUG-1:0] C_SEL_ONE   = N_JUG'(1);

  logic [ST_W-1:0]     r_state;
  logic [HW-1:0]       r_hold;
  logic                r_reset_cnt;
  logic [N_JUG-1:0]    r_ganador;
  logic [N_JUG*PW-1:0] r_puntos;
  logic                r_fin;

  logic [N_JUG-1:0]    w_rise;
  logic [N_JUG-1:0]    w_sel;
  logic                w_any;
  logic [PW-1:0]       w_cur_score;
  logic [PW-1:0]       w_new_score;
  logic                w_at_max;
  logic                w_reach_win;

  // One edge detector per player channel
  generate
    for (genvar gi = 0; gi < N_JUG; gi++) begin : g_edge
      detector_flanco u_det (
        .clk    (clk),
        .rst    (resetTotal),
        .i_sig  (Ganador[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  // Isolate the lowest set bit: lowest player index wins a tie
  assign w_sel = w_rise & (~w_rise + C_SEL_ONE);
  assign w_any = |w_rise;

  // Current score of the selected player
  always_comb begin
    w_cur_score = '0;
    for (int i = 0; i < N_JUG; i++) begin
      if (w_sel[i]) w_cur_score = r_puntos[i*PW +: PW];
    end
  end

  assign w_new_score = w_cur_score + C_SCORE_ONE;
  // A score already at the limit is never incremented (no wrap)
  assign w_at_max    = (w_cur_score == C_WIN);
  assign w_reach_win = w_at_max || (w_new_score == C_WIN);

  // Controller FSM; every output is a flop updated alongside the state
  always_ff @(posedge clk or posedge resetTotal) begin
    if (resetTotal) begin
      r_state     <= REINICIO;
      r_reset_cnt <= 1'b1;
      r_ganador   <= '0;
      r_puntos    <= '0;
      r_fin       <= 1'b0;
      r_hold      <= '0;
    end else begin
      case (r_state)
        JUEGO: begin
          if (Apagar) begin
            r_state     <= APAGADO;
            r_reset_cnt <= 1'b1;
            r_ganador   <= '0;
            r_puntos    <= '0;
            r_fin       <= 1'b0;
            r_hold      <= '0;
          end else if (w_any) begin
            r_ganador <= w_sel;
            for (int i = 0; i < N_JUG; i++) begin
              if (w_sel[i] && !w_at_max) r_puntos[i*PW +: PW] <= w_new_score;
            end
            if (w_reach_win) begin
              r_state     <= FIN;
              r_reset_cnt <= 1'b1;
              r_fin       <= 1'b1;
            end else begin
              r_state     <= CELEBRA;
              r_hold      <= C_HOLD_INIT;
              r_reset_cnt <= 1'b0;
            end
          end else begin
            r_reset_cnt <= 1'b0;
          end
        end

        CELEBRA: begin
          if (Apagar) begin
            r_state     <= APAGADO;
            r_reset_cnt <= 1'b1;
            r_ganador   <= '0;
            r_puntos    <= '0;
            r_fin       <= 1'b0;
            r_hold      <= '0;
          end else if (r_hold == C_HOLD_ZERO) begin
            r_state     <= REINICIO;
            r_reset_cnt <= 1'b1;
          end else begin
            r_hold <= r_hold - C_HOLD_ONE;
          end
        end

        REINICIO: begin
          r_state     <= JUEGO;
          r_reset_cnt <= 1'b0;
          r_ganador   <= '0;
        end

        FIN: begin
          if (Apagar) begin
            r_state     <= APAGADO;
            r_reset_cnt <= 1'b1;
            r_ganador   <= '0;
            r_puntos    <= '0;
            r_fin       <= 1'b0;
            r_hold      <= '0;
          end else begin
            r_reset_cnt <= 1'b1;
            r_fin       <= 1'b1;
          end
        end

        APAGADO: begin
          r_reset_cnt <= 1'b1;
          if (!Apagar) r_state <= REINICIO;
        end

        default: begin
          r_state     <= REINICIO;
          r_reset_cnt <= 1'b1;
          r_ganador   <= '0;
        end
      endcase
    end
  end

  assign resetContador = r_reset_cnt;
  assign ganadorRonda  = r_ganador;
  assign puntos        = r_puntos;
  assign partidaFin    = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_game_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_game_reset_ctrl
//  Self-checking bench for game_reset_ctrl with a cycle-level match model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_game_reset_ctrl;

  localparam int N_JUG      = 2;
  localparam int HOLD_CYC   = 4;
  localparam int WIN_ROUNDS = 3;
  localparam int PW         = 2;

  logic                clk = 1'b0;
  logic                resetTotal = 1'b0;
  logic [N_JUG-1:0]    Ganador = '0;
  logic                Apagar = 1'b0;
  logic                resetContador;
  logic [N_JUG-1:0]    ganadorRonda;
  logic [N_JUG*PW-1:0] puntos;
  logic                partidaFin;

  int n_vec = 0;
  int n_err = 0;

  game_reset_ctrl #(
    .N_JUG      (N_JUG),
    .HOLD_CYC   (HOLD_CYC),
    .WIN_ROUNDS (WIN_ROUNDS)
  ) dut (
    .clk           (clk),
    .resetTotal    (resetTotal),
    .Ganador       (Ganador),
    .Apagar        (Apagar),
    .resetContador (resetContador),
    .ganadorRonda  (ganadorRonda),
    .puntos        (puntos),
    .partidaFin    (partidaFin)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (match rules, not states) -------------
  int               m_score [N_JUG];
  logic [N_JUG-1:0] m_win;
  logic [N_JUG-1:0] m_prev;
  bit               m_over;     // match decided
  bit               m_off;      // powered off
  bit               m_pulse;    // one-cycle counter reset between rounds
  int               m_cel;      // celebration cycles still to run

  function automatic logic [N_JUG*PW-1:0] m_pts();
    logic [N_JUG*PW-1:0] res;
    res = '0;
    for (int i = 0; i < N_JUG; i++) res[i*PW +: PW] = PW'(m_score[i]);
    return res;
  endfunction

  function automatic logic m_rc();
    return m_over | m_off | m_pulse;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_JUG; i++) m_score[i] = 0;
    m_win = '0; m_over = 0; m_cel = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_off = 0; m_pulse = 1; m_prev = '1;
  endtask

  task automatic model_edge();
    logic [N_JUG-1:0] rises;
    int who;
    if (resetTotal) begin
      model_reset();
      return;
    end
    rises  = Ganador & ~m_prev;
    m_prev = Ganador;
    if (m_off) begin
      if (!Apagar) begin m_off = 0; m_pulse = 1; end
    end else if (m_pulse) begin
      m_pulse = 0; m_win = '0;
    end else if (m_over) begin
      if (Apagar) begin model_clear(); m_off = 1; end
    end else if (m_cel > 0) begin
      if (Apagar) begin model_clear(); m_off = 1; end
      else begin
        m_cel--;
        if (m_cel == 0) m_pulse = 1;
      end
    end else if (Apagar) begin
      model_clear(); m_off = 1;
    end else if (rises != 0) begin
      who = -1;
      for (int i = N_JUG - 1; i >= 0; i--) if (rises[i]) who = i;
      m_score[who]++;
      m_win = '0;
      m_win[who] = 1'b1;
      if (m_score[who] == WIN_ROUNDS) m_over = 1;
      else m_cel = HOLD_CYC;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 resetTotal = 1'b1;
    model_reset();
    #2;
    n_vec++;
    if ({resetContador, ganadorRonda, puntos, partidaFin} !== {1'b1, 2'b00, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: got rc=%b gr=%b pts=%b fin=%b, want rc=1 gr=00 pts=0000 fin=0",
               resetContador, ganadorRonda, puntos, partidaFin);
    end
    repeat (2) step();
    @(negedge clk) resetTotal = 1'b0;
    #1;
    n_vec++;
    if (resetContador !== 1'b1) begin
      n_err++; $display("FAIL reset_release_cycle: got rc=%b, want 1", resetContador);
    end
    step();
    n_vec++;
    if (resetContador !== 1'b0 || puntos !== 4'b0000) begin
      n_err++; $display("FAIL reset_to_play: got rc=%b pts=%b, want rc=0 pts=0000", resetContador, puntos);
    end
  endtask

  task automatic test_single_win();
    Ganador = 2'b01;
    step();
    Ganador = 2'b00;
    n_vec++;
    if (ganadorRonda !== 2'b01 || puntos !== 4'b0001 || resetContador !== 1'b0) begin
      n_err++;
      $display("FAIL single_win_n1: got gr=%b pts=%b rc=%b, want gr=01 pts=0001 rc=0",
               ganadorRonda, puntos, resetContador);
    end
    for (int k = 2; k <= 6; k++) begin
      step();
      n_vec++;
      if (resetContador !== (k == 5) || resetContador !== m_rc() || ganadorRonda !== m_win) begin
        n_err++;
        $display("FAIL single_win_pulse n+%0d: got rc=%b gr=%b, want rc=%b gr=%b",
                 k, resetContador, ganadorRonda, (k == 5), m_win);
      end
    end
  endtask

  task automatic test_simultaneous();
    Ganador = 2'b11;
    step();
    Ganador = 2'b00;
    n_vec++;
    if (ganadorRonda !== 2'b01 || puntos !== 4'b0010 || puntos !== m_pts()) begin
      n_err++;
      $display("FAIL simultaneous: got gr=%b pts=%b, want gr=01 pts=0010", ganadorRonda, puntos);
    end
    repeat (6) step();
  endtask

  task automatic test_held();
    Ganador = 2'b10;
    for (int k = 0; k < 20; k++) begin
      step();
      n_vec++;
      if (resetContador !== m_rc() || ganadorRonda !== m_win || puntos !== m_pts()) begin
        n_err++;
        $display("FAIL held cyc%0d: got rc=%b gr=%b pts=%b, want rc=%b gr=%b pts=%b",
                 k, resetContador, ganadorRonda, puntos, m_rc(), m_win, m_pts());
      end
    end
    Ganador = 2'b00;
    step();
    n_vec++;
    if (puntos !== 4'b0110) begin
      n_err++; $display("FAIL held_single_score: got pts=%b, want 0110", puntos);
    end
  endtask

  task automatic test_match_end();
    for (int w = 0; w < 2; w++) begin
      Ganador = 2'b10;
      step();
      Ganador = 2'b00;
      repeat (6) step();
    end
    n_vec++;
    if (puntos !== 4'b1110 || partidaFin !== 1'b1 || resetContador !== 1'b1 || ganadorRonda !== 2'b10) begin
      n_err++;
      $display("FAIL match_end: got pts=%b fin=%b rc=%b gr=%b, want pts=1110 fin=1 rc=1 gr=10",
               puntos, partidaFin, resetContador, ganadorRonda);
    end
    for (int k = 0; k < 8; k++) begin
      Ganador = k[1:0];
      step();
      n_vec++;
      if (puntos !== 4'b1110 || partidaFin !== 1'b1 || resetContador !== 1'b1 || ganadorRonda !== 2'b10) begin
        n_err++;
        $display("FAIL fin_frozen cyc%0d: got pts=%b fin=%b rc=%b gr=%b", k, puntos, partidaFin,
                 resetContador, ganadorRonda);
      end
    end
    Ganador = 2'b00;
  endtask

  task automatic test_apagar();
    @(negedge clk) resetTotal = 1'b1;
    step();
    @(negedge clk) resetTotal = 1'b0;
    step();
    step();
    Ganador = 2'b01;
    step();
    Ganador = 2'b00;
    step();
    Apagar = 1'b1;
    step();
    n_vec++;
    if (resetContador !== 1'b1 || puntos !== 4'b0000 || ganadorRonda !== 2'b00 || partidaFin !== 1'b0) begin
      n_err++;
      $display("FAIL apagar_enter: got rc=%b pts=%b gr=%b fin=%b, want 1 0000 00 0",
               resetContador, puntos, ganadorRonda, partidaFin);
    end
    repeat (3) step();
    Apagar = 1'b0;
    step();
    n_vec++;
    if (resetContador !== 1'b1) begin
      n_err++; $display("FAIL apagar_reinicio: got rc=%b, want 1", resetContador);
    end
    step();
    n_vec++;
    if (resetContador !== 1'b0 || resetContador !== m_rc()) begin
      n_err++; $display("FAIL apagar_to_play: got rc=%b, want 0", resetContador);
    end
  endtask

  task automatic test_async_reset();
    Ganador = 2'b10;
    step();
    Ganador = 2'b00;
    step();
    #2 resetTotal = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({resetContador, ganadorRonda, puntos, partidaFin} !== {1'b1, 2'b00, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL async_mid_celebra: got rc=%b gr=%b pts=%b fin=%b, want rc=1 gr=00 pts=0000 fin=0",
               resetContador, ganadorRonda, puntos, partidaFin);
    end
    @(negedge clk) resetTotal = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++;
      if (resetContador !== 1'b0 || resetContador !== m_rc() || puntos !== 4'b0000) begin
        n_err++; $display("FAIL async_no_extra_pulse cyc%0d: got rc=%b pts=%b, want rc=0 pts=0000",
                          k, resetContador, puntos);
      end
    end
  endtask

  task automatic test_random();
    bit rst_pending;
    rst_pending = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) Ganador = N_JUG'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) Apagar = ~Apagar;
      if (rst_pending) begin resetTotal = 1'b0; rst_pending = 0; end
      else if ($urandom_range(0, 149) == 0) begin resetTotal = 1'b1; rst_pending = 1; end
      step();
      n_vec++;
      if (resetContador !== m_rc() || ganadorRonda !== m_win || puntos !== m_pts() ||
          partidaFin !== m_over) begin
        n_err++;
        $display("FAIL random cyc%0d: got rc=%b gr=%b pts=%b fin=%b, want rc=%b gr=%b pts=%b fin=%b",
                 k, resetContador, ganadorRonda, puntos, partidaFin, m_rc(), m_win, m_pts(), m_over);
      end
    end
    resetTotal = 1'b0;
    Apagar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_win();
    test_simultaneous();
    test_held();
    test_match_end();
    test_apagar();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
